// File: rtl/edge_event_scheduler_pkg.sv
// Shared definitions for the edge event scheduler.
//   N_DEFAULT / ID_W_DEFAULT : default channel count and index width
//   sched_state_t            : offer FSM state encoding
//   rr_next()                : round-robin search for the next pending channel
package edge_sched_pkg;

    localparam int N_DEFAULT    = 4;
    localparam int ID_W_DEFAULT = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_t;

    // Searches ptr+1, ptr+2, ... modulo n and returns {found, index} for the
    // first set bit of pend. The loop is fixed at 16 iterations so it unrolls
    // to a constant-size priority chain for any legal n (2..16).
    function automatic logic [4:0] rr_next(input logic [15:0] pend,
                                           input int          ptr,
                                           input int          n);
        logic       found;
        logic [3:0] idx;
        int         c;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= n && !found) begin
                c = (ptr + k) % n;
                if (pend[c[3:0]]) begin
                    found = 1'b1;
                    idx   = c[3:0];
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/edge_event_scheduler_if.sv
// Event port between the scheduler (master) and a single consumer (slave).
//   evt_valid : event offer valid            (master -> slave)
//   evt_ready : consumer accepts the offer   (slave -> master)
//   evt_id    : channel index of the event   (master -> slave)
//   evt_rise  : 1 = rising edge, 0 = falling (master -> slave)
interface edge_event_scheduler_if #(
    parameter int ID_W = 2
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_rise;

    modport master (output evt_valid, output evt_id, output evt_rise, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_rise, output evt_ready);
endinterface

// File: rtl/edge_event_scheduler_channel.sv
// One input channel: edge detector, single-entry pending slot with polarity,
// and a sticky overflow flag for edges that arrive while the slot is full.
//   clk, reset      : clock, async active-high reset
//   i_sig           : sampled input (synchronous to clk)
//   i_set_ovf_clr   : clear overflow (a same-cycle new overflow wins)
//   i_retire        : this channel's event is being accepted this cycle
//   o_pending/o_pol : queued event and its polarity
//   o_overflow      : sticky lost-edge flag
module edge_channel (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    input  logic i_set_ovf_clr,
    input  logic i_retire,
    output logic o_pending,
    output logic o_pol,
    output logic o_overflow
);
    logic r_last;
    logic r_pending;
    logic r_pol;
    logic r_overflow;
    logic w_edge;

    assign w_edge = i_sig != r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last     <= 1'b0;
            r_pending  <= 1'b0;
            r_pol      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_last <= i_sig;
            // A retiring slot is free this cycle, so a coincident edge refills it.
            if (w_edge && (!r_pending || i_retire)) begin
                r_pending <= 1'b1;
                r_pol     <= i_sig;
            end else if (i_retire) begin
                r_pending <= 1'b0;
            end
            if (w_edge && r_pending && !i_retire)
                r_overflow <= 1'b1;
            else if (i_set_ovf_clr)
                r_overflow <= 1'b0;
        end
    end

    assign o_pending  = r_pending;
    assign o_pol      = r_pol;
    assign o_overflow = r_overflow;
endmodule

// File: rtl/edge_event_scheduler.sv
// Detects rising/falling edges on N synchronous inputs, holds one pending
// event per channel and serialises them round-robin onto a valid/ready port.
//   clk, reset       : clock, async active-high reset
//   i_sig            : N sampled inputs
//   i_clr_overflow   : clear all overflow flags
//   o_overflow       : per-channel sticky lost-edge flags
//   bus (master)     : evt_valid/evt_ready/evt_id/evt_rise event port
module edge_event_scheduler
    import edge_sched_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int ID_W = ID_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           i_sig,
    input  logic                   i_clr_overflow,
    output logic [N-1:0]           o_overflow,
    edge_event_scheduler_if.master bus
);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    sched_state_t    r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_evt_id;
    logic            r_evt_rise;
    logic            r_evt_valid;

    logic [N-1:0]    w_pending;
    logic [N-1:0]    w_pol;
    logic [N-1:0]    w_retire;
    logic            w_handshake;
    logic [4:0]      w_sel_idle;
    logic [4:0]      w_sel_next;
    logic [ID_W-1:0] w_idle_id;
    logic [ID_W-1:0] w_next_id;

    assign w_handshake = r_evt_valid & bus.evt_ready;
    assign w_retire    = w_handshake ? (ONE << r_evt_id) : '0;

    for (genvar g = 0; g < N; g++) begin : g_ch
        edge_channel u_ch (
            .clk           (clk),
            .reset         (reset),
            .i_sig         (i_sig[g]),
            .i_set_ovf_clr (i_clr_overflow),
            .i_retire      (w_retire[g]),
            .o_pending     (w_pending[g]),
            .o_pol         (w_pol[g]),
            .o_overflow    (o_overflow[g])
        );
    end

    // Arbitration sees registered pending only; the channel being retired is
    // masked so it goes to the back of the round-robin order.
    always_comb begin
        w_sel_idle = rr_next(16'(w_pending), int'(r_ptr), N);
        w_sel_next = rr_next(16'(w_pending & ~(ONE << r_evt_id)), int'(r_evt_id), N);
        w_idle_id  = ID_W'(w_sel_idle[3:0]);
        w_next_id  = ID_W'(w_sel_next[3:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= ID_W'(N - 1);
            r_evt_id    <= '0;
            r_evt_rise  <= 1'b0;
            r_evt_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_idle[4]) begin
                        r_evt_id    <= w_idle_id;
                        r_evt_rise  <= w_pol[w_idle_id];
                        r_evt_valid <= 1'b1;
                        r_state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.evt_ready) begin
                        r_ptr <= r_evt_id;
                        if (w_sel_next[4]) begin
                            r_evt_id   <= w_next_id;
                            r_evt_rise <= w_pol[w_next_id];
                        end else begin
                            r_evt_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_evt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.evt_valid = r_evt_valid;
    assign bus.evt_id    = r_evt_id;
    assign bus.evt_rise  = r_evt_rise;
endmodule

// File: tb/tb_edge_event_scheduler.sv
module tb_edge_event_scheduler;
    localparam int N    = 4;
    localparam int ID_W = 2;

    logic         clk;
    logic         reset;
    logic [N-1:0] sig;
    logic         clr_overflow;
    logic [N-1:0] overflow;
    int           checks;
    int           errors;

    edge_event_scheduler_if #(.ID_W(ID_W)) ifc ();

    edge_event_scheduler #(.N(N), .ID_W(ID_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_sig          (sig),
        .i_clr_overflow (clr_overflow),
        .o_overflow     (overflow),
        .bus            (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_offer(input string tag, input logic v, input logic [ID_W-1:0] id,
                               input logic rise);
        check({tag, "_valid"}, 16'(ifc.evt_valid), 16'(v));
        if (v) begin
            check({tag, "_id"},   16'(ifc.evt_id),   16'(id));
            check({tag, "_rise"}, 16'(ifc.evt_rise), 16'(rise));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        sig          = '0;
        clr_overflow = 1'b0;
        ifc.evt_ready = 1'b0;

        // reset values
        tick();
        tick();
        check("rst_valid", 16'(ifc.evt_valid), 16'd0);
        check("rst_id",    16'(ifc.evt_id),    16'd0);
        check("rst_rise",  16'(ifc.evt_rise),  16'd0);
        check("rst_ovf",   16'(overflow),      16'd0);
        reset = 1'b0;
        tick();
        tick();
        check_offer("idle_quiet", 1'b0, 2'd0, 1'b0);

        // single rising edge on ch2: pending after one edge, offer on the next
        sig = 4'b0100;
        tick();
        check_offer("lat_k", 1'b0, 2'd0, 1'b0);
        ifc.evt_ready = 1'b1;
        tick();
        check_offer("lat_k1", 1'b1, 2'd2, 1'b1);
        tick();
        check_offer("lat_k2", 1'b0, 2'd0, 1'b0);

        // all four rise together: back-to-back ids 0..3
        ifc.evt_ready = 1'b0;
        sig = '0;
        do_reset();
        ifc.evt_ready = 1'b1;
        sig = 4'b1111;
        tick();
        check_offer("b2b_cap", 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_offer("b2b", 1'b1, ID_W'(i), 1'b1);
            check("b2b_ovf", 16'(overflow), 16'd0);
        end
        tick();
        check_offer("b2b_end", 1'b0, 2'd0, 1'b0);

        // stalled offer on ch1 with extra toggles -> overflow, offer unchanged
        ifc.evt_ready = 1'b0;
        sig = '0;
        do_reset();
        sig = 4'b0010;
        tick();
        tick();
        check_offer("stall_a", 1'b1, 2'd1, 1'b1);
        sig = 4'b0000;
        tick();
        check_offer("stall_b", 1'b1, 2'd1, 1'b1);
        check("stall_ovf1", 16'(overflow), 16'h2);
        sig = 4'b0010;
        tick();
        check_offer("stall_c", 1'b1, 2'd1, 1'b1);
        check("stall_ovf2", 16'(overflow), 16'h2);
        clr_overflow = 1'b1;
        tick();
        check("ovf_clr", 16'(overflow), 16'h0);
        sig = 4'b0000;
        tick();
        check("ovf_set_wins", 16'(overflow), 16'h2);
        tick();
        check("ovf_clr2", 16'(overflow), 16'h0);
        clr_overflow = 1'b0;
        check_offer("stall_d", 1'b1, 2'd1, 1'b1);
        ifc.evt_ready = 1'b1;
        tick();
        check_offer("stall_done", 1'b0, 2'd0, 1'b0);

        // edge on ch3 during its own handshake while ch0 is pending
        ifc.evt_ready = 1'b0;
        sig = '0;
        do_reset();
        sig = 4'b1000;
        tick();
        tick();
        check_offer("coin_a", 1'b1, 2'd3, 1'b1);
        sig = 4'b1001;
        tick();
        check_offer("coin_b", 1'b1, 2'd3, 1'b1);
        ifc.evt_ready = 1'b1;
        sig = 4'b0001;
        tick();
        check_offer("coin_ch0", 1'b1, 2'd0, 1'b1);
        check("coin_ovf", 16'(overflow), 16'h0);
        tick();
        check_offer("coin_ch3", 1'b1, 2'd3, 1'b0);
        tick();
        check_offer("coin_end", 1'b0, 2'd0, 1'b0);
        check("coin_ovf2", 16'(overflow), 16'h0);

        // asynchronous reset during an offer
        ifc.evt_ready = 1'b0;
        sig = '0;
        do_reset();
        sig = 4'b0100;
        tick();
        tick();
        sig = 4'b0000;
        tick();
        check_offer("arst_pre", 1'b1, 2'd2, 1'b1);
        check("arst_pre_ovf", 16'(overflow), 16'h4);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 16'(ifc.evt_valid), 16'd0);
        check("arst_ovf",   16'(overflow),      16'd0);
        check("arst_pend",  16'(dut.w_pending), 16'd0);

        // sig[0] held high through reset release -> exactly one rise event
        sig = 4'b0001;
        ifc.evt_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_offer("hold_k", 1'b0, 2'd0, 1'b0);
        tick();
        check_offer("hold_k1", 1'b1, 2'd0, 1'b1);
        tick();
        check_offer("hold_k2", 1'b0, 2'd0, 1'b0);
        tick();
        check_offer("hold_k3", 1'b0, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
